fifo_wr_arbiter: RTL and testbench

- Two-requester write-side controller for the 8-bit synchronous FIFO.
- Arbitrates two valid/ready producers onto the FIFO's single wr_enb/wr_data port, using round-robin with bounded burst ownership.
- Tracks FIFO occupancy internally with credits, so a write is never issued into a full FIFO. The FIFO's overrun condition is therefore unreachable in normal operation.
- Sits between producer logic and the FIFO write port; the read side remains owned by the consumer.

---
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between two producers, the write arbiter and the FIFO ports it watches.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DW = 8
);
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          wr_enb;
    logic [DW-1:0] wr_data;
    logic          rd_enb;
    logic          fifo_empty;
    logic          fifo_full;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  rd_enb, fifo_empty, fifo_full,
        output req0_ready, req1_ready, wr_enb, wr_data
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        output rd_enb, fifo_empty, fifo_full,
        input  req0_ready, req1_ready, wr_enb, wr_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-producer round-robin write arbiter with bounded bursts and credit-tracked FIFO occupancy.
module fifo_wr_arbiter #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fifo_wr_arbiter_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [1:0]                   owner,
    output logic                         err_overrun
);
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned SW = OW + 1;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic          rr_ptr, rr_nxt;

    logic [1:0]    vld;
    logic          own_hit;
    logic          gnt_vld;
    logic          gnt_id;
    logic [DW-1:0] gnt_data;
    logic [SW-1:0] used;
    logic          space_ok;
    logic          accept;
    logic          rd_dec;

    assign vld = {bus.req1_valid, bus.req0_valid};

    // Grant: continue current burst, else round-robin pointer, else the other requester
    always_comb begin
        own_hit = 1'b0;
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state == OWN0 && vld[0] && beat_cnt < BW'(BURST_MAX)) begin
            own_hit = 1'b1;
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end else if (state == OWN1 && vld[1] && beat_cnt < BW'(BURST_MAX)) begin
            own_hit = 1'b1;
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end else if (vld[rr_ptr]) begin
            gnt_vld = 1'b1;
            gnt_id  = rr_ptr;
        end else if (vld[~rr_ptr]) begin
            gnt_vld = 1'b1;
            gnt_id  = ~rr_ptr;
        end
    end

    // The in-flight write already consumes a credit; a same-cycle read does not free one
    always_comb begin
        used     = SW'(occupancy) + SW'(bus.wr_enb);
        space_ok = (used < SW'(DEPTH));
        accept   = gnt_vld & space_ok & rst_n;
        gnt_data = gnt_id ? bus.req1_data : bus.req0_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            rr_ptr   <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        rr_nxt    = rr_ptr;
        if (accept) begin
            if (own_hit) begin
                beat_nxt = beat_cnt + BW'(1);
            end else begin
                state_nxt = gnt_id ? OWN1 : OWN0;
                beat_nxt  = BW'(1);
                rr_nxt    = ~gnt_id;
            end
        end else if (vld == 2'b00) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
        end
    end

    always_comb begin
        bus.req0_ready = accept & ~gnt_id;
        bus.req1_ready = accept & gnt_id;
        owner          = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_enb  <= 1'b0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_enb <= accept;
            if (accept) begin
                bus.wr_data <= gnt_data;
            end
        end
    end

    assign rd_dec = bus.rd_enb & ~bus.fifo_empty & (occupancy != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (bus.wr_enb && !rd_dec && occupancy != OW'(DEPTH)) begin
            occupancy <= occupancy + OW'(1);
        end else if (rd_dec && !bus.wr_enb) begin
            occupancy <= occupancy - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overrun <= 1'b0;
        end else if (bus.wr_enb && bus.fifo_full) begin
            err_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference.
module tb_fifo_wr_arbiter;
    localparam int DEPTH = 8;
    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] occupancy;
    logic [1:0] owner;
    logic       err_overrun;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DW(8)) bus ();

    fifo_wr_arbiter #(.DEPTH(DEPTH), .DW(8), .BURST_MAX(BURST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .occupancy   (occupancy),
        .owner       (owner),
        .err_overrun (err_overrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: owner (0 idle, 1 req0, 2 req1), beats in current ownership, rr pointer
    int         m_occ, m_wr, m_own, m_beat, m_rr, m_err;
    logic [7:0] m_wd;
    logic [7:0] fq[$];
    logic [7:0] wlog[$];
    logic [7:0] exp_w[$];
    logic [7:0] d[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int grant();
        int v[2];
        v[0] = int'(bus.req0_valid);
        v[1] = int'(bus.req1_valid);
        if (m_own != 0 && v[m_own-1] == 1 && m_beat < BURST) return m_own - 1;
        if (v[m_rr] == 1) return m_rr;
        if (v[1-m_rr] == 1) return 1 - m_rr;
        return -1;
    endfunction

    function automatic int exp_ready(input int r);
        if (rst_n !== 1'b1) return 0;
        return (grant() == r && (m_occ + m_wr) < DEPTH) ? 1 : 0;
    endfunction

    task automatic set_flags();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_full  = (fq.size() == DEPTH);
    endtask

    task automatic model_reset();
        m_occ = 0; m_wr = 0; m_wd = 8'h00; m_own = 0; m_beat = 0; m_rr = 0; m_err = 0;
        fq.delete(); wlog.delete(); exp_w.delete();
        set_flags();
    endtask

    task automatic drive_data();
        bus.req0_data = d[0];
        bus.req1_data = d[1];
    endtask

    // Compare every DUT output against the reference (called at the falling edge)
    task automatic cmp();
        chk("req0_ready", int'(bus.req0_ready), exp_ready(0));
        chk("req1_ready", int'(bus.req1_ready), exp_ready(1));
        chk("wr_enb",     int'(bus.wr_enb),     m_wr);
        chk("wr_data",    int'(bus.wr_data),    int'(m_wd));
        chk("occupancy",  int'(occupancy),      m_occ);
        chk("owner",      int'(owner),          m_own);
        chk("err_overrun", int'(err_overrun),   m_err);
    endtask

    // Advance one rising edge: reference, attached FIFO and write scoreboard
    task automatic step(output bit acc, output int g);
        int  v0, v1;
        bit  own_hit, rd, empty, full, dut_wr, rd_eff;
        logic [7:0] dut_wd;
        v0      = int'(bus.req0_valid);
        v1      = int'(bus.req1_valid);
        g       = grant();
        own_hit = (m_own != 0) && (g == m_own - 1) && (m_beat < BURST);
        acc     = (rst_n === 1'b1) && (g >= 0) && ((m_occ + m_wr) < DEPTH);
        rd      = bus.rd_enb;
        empty   = bus.fifo_empty;
        full    = bus.fifo_full;
        dut_wr  = bus.wr_enb;
        dut_wd  = bus.wr_data;
        @(posedge clk);
        if (rst_n === 1'b1) begin
            rd_eff = rd && !empty && m_occ != 0;
            if (m_wr == 1 && !rd_eff && m_occ < DEPTH) m_occ++;
            else if (rd_eff && m_wr == 0) m_occ--;
            if (m_wr == 1 && full) m_err = 1;
            if (rd && fq.size() > 0) void'(fq.pop_front());
            if (dut_wr) begin
                if (fq.size() < DEPTH) fq.push_back(dut_wd);
                wlog.push_back(dut_wd);
                if (exp_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_order: unexpected write %0h, none pending", dut_wd);
                end else begin
                    chk("write_order", int'(dut_wd), int'(exp_w.pop_front()));
                end
            end
            if (acc) begin
                m_wr = 1;
                m_wd = d[g];
                exp_w.push_back(d[g]);
                if (own_hit) m_beat++;
                else begin
                    m_own  = g + 1;
                    m_beat = 1;
                    m_rr   = 1 - g;
                end
            end else begin
                m_wr = 0;
                if (v0 == 0 && v1 == 0) begin
                    m_own  = 0;
                    m_beat = 0;
                end
            end
        end
        #1;
        set_flags();
    endtask

    task automatic cyc(input bit seq);
        bit acc;
        int g;
        @(negedge clk);
        cmp();
        step(acc, g);
        if (acc) d[g] = seq ? d[g] + 8'd1 : 8'($urandom);
        drive_data();
    endtask

    task automatic do_reset();
        bit acc;
        int g;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rd_enb     = 1'b0;
        rst_n = 1'b0;
        model_reset();
        step(acc, g);
        rst_n = 1'b1;
    endtask

    initial begin
        int  exp_c[8];
        bit  acc;
        int  g;
        exp_c = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};

        // Reset held two cycles with req0 asking; nothing may be accepted
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rd_enb = 1'b0;
        d[0] = 8'h10;
        d[1] = 8'h20;
        drive_data();
        model_reset();
        repeat (2) begin
            @(negedge clk);
            cmp();
            chk("rst_req0_ready", int'(bus.req0_ready), 0);
            chk("rst_wr_enb", int'(bus.wr_enb), 0);
            step(acc, g);
        end
        rst_n = 1'b1;

        // Contention from reset: bursts of four, then credits run out
        @(negedge clk);
        chk("post_rst_occ", int'(occupancy), 0);
        chk("post_rst_owner", int'(owner), 0);
        cmp();
        step(acc, g);
        if (acc) d[g] = d[g] + 8'd1;
        drive_data();
        repeat (11) cyc(1'b1);
        @(negedge clk);
        chk("full_occ", int'(occupancy), 8);
        chk("full_ready0", int'(bus.req0_ready), 0);
        chk("full_ready1", int'(bus.req1_ready), 0);
        chk("full_err", int'(err_overrun), 0);
        chk("full_count", wlog.size(), 8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) chk("contention_seq", int'(wlog[i]), exp_c[i]);

        // Drain one entry from full, then refill
        bus.rd_enb = 1'b1;
        cmp();
        chk("rd_same_cycle_ready", int'(bus.req0_ready | bus.req1_ready), 0);
        step(acc, g);
        if (acc) d[g] = d[g] + 8'd1;
        drive_data();
        bus.rd_enb = 1'b0;
        @(negedge clk);
        chk("drain_occ", int'(occupancy), 7);
        chk("drain_ready", int'(bus.req0_ready | bus.req1_ready), 1);
        cmp();
        step(acc, g);
        drive_data();
        cyc(1'b1);
        @(negedge clk);
        chk("refill_occ", int'(occupancy), 8);

        // Single beat of A5 from req0
        do_reset();
        d[0] = 8'hA5;
        drive_data();
        bus.req0_valid = 1'b1;
        @(negedge clk);
        chk("single_ready0", int'(bus.req0_ready), 1);
        cmp();
        step(acc, g);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("single_wr_enb", int'(bus.wr_enb), 1);
        chk("single_wr_data", int'(bus.wr_data), 8'hA5);
        chk("single_owner", int'(owner), 1);
        cmp();
        step(acc, g);
        @(negedge clk);
        chk("single_wr_enb_off", int'(bus.wr_enb), 0);
        chk("single_occ", int'(occupancy), 1);
        chk("single_owner_idle", int'(owner), 0);

        // req1 owns for two beats, then drops while req0 waits
        do_reset();
        d[0] = 8'h30;
        d[1] = 8'h40;
        drive_data();
        bus.req1_valid = 1'b1;
        cyc(1'b1);
        bus.req0_valid = 1'b1;
        @(negedge clk);
        chk("drop_ready1", int'(bus.req1_ready), 1);
        cmp();
        step(acc, g);
        if (acc) d[g] = d[g] + 8'd1;
        drive_data();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("drop_ready0", int'(bus.req0_ready), 1);
        cmp();
        step(acc, g);
        @(negedge clk);
        chk("drop_owner", int'(owner), 1);

        // Asynchronous reset while a write is in flight
        do_reset();
        bus.req0_valid = 1'b1;
        repeat (3) cyc(1'b1);
        chk("mid_wr_enb", int'(bus.wr_enb), 1);
        chk("mid_occ", int'(occupancy), 2);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_wr_enb", int'(bus.wr_enb), 0);
        chk("async_occ", int'(occupancy), 0);
        chk("async_owner", int'(owner), 0);
        cyc(1'b1);
        rst_n = 1'b1;

        // Random traffic against the reference
        do_reset();
        d[0] = 8'($urandom);
        d[1] = 8'($urandom);
        drive_data();
        for (int c = 0; c < 3000; c++) begin
            bus.req0_valid = ($urandom_range(0, 9) < 7);
            bus.req1_valid = ($urandom_range(0, 9) < 6);
            bus.rd_enb     = ($urandom_range(0, 9) < 4);
            cyc(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
